trng_collector: RTL



---
 rtl/trng_collector.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/trng_collector.sv
// Ring-oscillator TRNG consumer: warm-up, repetition-count health test, word packing, show-ahead FIFO.
// Define TRNG_COLLECTOR_VON_NEUMANN_EN to debias raw bits in pairs (01->0, 10->1, 00/11 dropped).
module trng_collector #(
   parameter int unsigned WORD_WIDTH    = 32,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned WARMUP_CYCLES = 16,
   parameter int unsigned REP_LIMIT     = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               enable,
   output logic                               trng_en,
   input  logic                               trng_in,
   output logic [WORD_WIDTH-1:0]              rdata,
   output logic                               rvalid,
   input  logic                               rready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
   output logic                               health_fail,
   output logic                               busy
);

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned BIT_W = $clog2(WORD_WIDTH + 1);
   localparam int unsigned WU_W  = $clog2(WARMUP_CYCLES + 1);
   localparam int unsigned RUN_W = $clog2(REP_LIMIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COLLECT, S_FAULT} state_t;

   state_t                 state_q, state_d;
   logic [WU_W-1:0]        wu_cnt_q;
   logic [BIT_W-1:0]       bit_cnt_q;
   logic [WORD_WIDTH-1:0]  word_q;
   logic                   pend_q;
   logic [RUN_W-1:0]       run_cnt_q, run_cnt_d;
   logic                   prev_q;
   logic [WORD_WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic [WORD_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   trng_en_q, health_fail_q, busy_q;

   logic                   collecting, fault, take, pop, slot_free;
   logic                   bit_ok, bit_val, word_done, push;
   logic [WORD_WIDTH-1:0]  word_next, push_data;
`ifdef TRNG_COLLECTOR_VON_NEUMANN_EN
   logic                   phase_q, phase_d, first_q, first_d;
`endif

   assign trng_en     = trng_en_q;
   assign health_fail = health_fail_q;
   assign busy        = busy_q;
   assign rvalid      = (level_q != '0);
   assign fifo_level  = level_q;
   assign rdata       = rdata_q;

   always_comb begin
      collecting = (state_q == S_COLLECT) && enable;
      run_cnt_d  = ((run_cnt_q == '0) || (trng_in != prev_q)) ? RUN_W'(1) : run_cnt_q + RUN_W'(1);
      fault      = collecting && (run_cnt_d == RUN_W'(REP_LIMIT));
      take       = collecting && !fault && !pend_q;
      pop        = rvalid && rready;
      slot_free  = (level_q != LVL_W'(FIFO_DEPTH)) || pop;
`ifdef TRNG_COLLECTOR_VON_NEUMANN_EN
      phase_d = phase_q;
      first_d = first_q;
      bit_ok  = 1'b0;
      bit_val = first_q;
      if (take) begin
         if (!phase_q) begin
            phase_d = 1'b1;
            first_d = trng_in;
         end else begin
            phase_d = 1'b0;
            bit_ok  = (first_q != trng_in);
         end
      end
`else
      bit_ok  = take;
      bit_val = trng_in;
`endif
      word_next = {word_q[WORD_WIDTH-2:0], bit_val};
      word_done = bit_ok && (bit_cnt_q == BIT_W'(WORD_WIDTH - 1));
      push      = collecting && !fault && slot_free && (pend_q || word_done);
      push_data = pend_q ? word_q : word_next;

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
      // Head register: bypass the word being written when it becomes the new head.
      if (level_d == '0)
         rdata_d = rdata_q;
      else if (push && (wr_ptr_q == rd_ptr_d))
         rdata_d = push_data;
      else
         rdata_d = mem_q[rd_ptr_d];

      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (enable) state_d = S_WARMUP;
         S_WARMUP: begin
            if (!enable)
               state_d = S_IDLE;
            else if (wu_cnt_q == WU_W'(WARMUP_CYCLES - 1))
               state_d = S_COLLECT;
         end
         S_COLLECT: begin
            if (!enable)
               state_d = S_IDLE;
            else if (fault)
               state_d = S_FAULT;
         end
         S_FAULT:   if (!enable) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         trng_en_q     <= 1'b0;
         health_fail_q <= 1'b0;
         busy_q        <= 1'b0;
         wu_cnt_q      <= '0;
         bit_cnt_q     <= '0;
         word_q        <= '0;
         pend_q        <= 1'b0;
         run_cnt_q     <= '0;
         prev_q        <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         rdata_q       <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef TRNG_COLLECTOR_VON_NEUMANN_EN
         phase_q       <= 1'b0;
         first_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         trng_en_q     <= (state_d == S_WARMUP) || (state_d == S_COLLECT);
         busy_q        <= (state_d == S_WARMUP) || (state_d == S_COLLECT);
         health_fail_q <= (state_d == S_FAULT);
         wu_cnt_q      <= (state_q == S_WARMUP) ? wu_cnt_q + WU_W'(1) : '0;

         if ((state_q != S_COLLECT) || (state_d != S_COLLECT)) begin
            bit_cnt_q <= '0;
            pend_q    <= 1'b0;
            run_cnt_q <= '0;
`ifdef TRNG_COLLECTOR_VON_NEUMANN_EN
            phase_q   <= 1'b0;
`endif
         end else begin
            run_cnt_q <= run_cnt_d;
            prev_q    <= trng_in;
            pend_q    <= pend_q ? !slot_free : (word_done && !slot_free);
            if (bit_ok) begin
               word_q    <= word_next;
               bit_cnt_q <= word_done ? '0 : bit_cnt_q + BIT_W'(1);
            end
`ifdef TRNG_COLLECTOR_VON_NEUMANN_EN
            phase_q   <= phase_d;
            first_q   <= first_d;
`endif
         end

         if (push) mem_q[wr_ptr_q] <= push_data;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule
